// File: rtl/debounce_scheduler.sv
// Multi-channel debouncer: one prescaler and one scan engine shared across all channels, with level-change events reported over valid/ready.
// Define DEBOUNCE_EVENT_FIFO_EN for a FIFO_DEPTH-entry event queue; otherwise a single holding register is used.
module debounce_scheduler #(
   parameter int CHANNELS   = 4,
   parameter int TICK_DIV   = 1000,
   parameter int STABLE_CNT = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [CHANNELS-1:0]         signal_in,
   output logic [CHANNELS-1:0]         signal_out,
   output logic                        evt_valid,
   input  logic                        evt_ready,
   output logic [$clog2(CHANNELS)-1:0] evt_chan,
   output logic                        evt_level,
   output logic                        evt_overflow,
   output logic                        busy
);

   localparam int CHW  = $clog2(CHANNELS);
   localparam int CNTW = $clog2(STABLE_CNT + 1);
   localparam int PW   = $clog2(TICK_DIV);
   localparam int EW   = CHW + 1;

   generate
      if (CHANNELS < 2 || CHANNELS > 32) begin : g_bad_channels
         $error("debounce_scheduler: CHANNELS must be 2..32");
      end
      if (TICK_DIV < CHANNELS + 2) begin : g_bad_tick_div
         $error("debounce_scheduler: TICK_DIV must be >= CHANNELS+2");
      end
      if (STABLE_CNT < 2) begin : g_bad_stable_cnt
         $error("debounce_scheduler: STABLE_CNT must be >= 2");
      end
      if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
         $error("debounce_scheduler: FIFO_DEPTH must be a power of two >= 2");
      end
   endgenerate

   typedef enum logic {IDLE, SCAN} state_t;

   state_t                state_q, state_d;
   logic [CHW-1:0]        ch_q, ch_d;
   logic [PW-1:0]         presc_q, presc_d;
   logic [CHANNELS-1:0]   sync1_q, sync1_d, sync2_q, sync2_d;
   logic [CHANNELS-1:0]   out_q, out_d;
   logic [CNTW-1:0]       cnt_q [CHANNELS];
   logic [CNTW-1:0]       cnt_d [CHANNELS];
   logic                  valid_q, valid_d;
   logic                  ovf_q, ovf_d;
   logic                  tick;
   logic                  push;
   logic                  push_level;
   logic                  pop;
   logic [EW-1:0]         head;

   always_comb begin
      sync1_d = signal_in;
      sync2_d = sync1_q;
      tick    = (presc_q == PW'(TICK_DIV - 1));
      presc_d = tick ? '0 : presc_q + PW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         presc_q <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         presc_q <= presc_d;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         ch_q    <= '0;
      end else begin
         state_q <= state_d;
         ch_q    <= ch_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      case (state_q)
         IDLE: if (tick) begin
            state_d = SCAN;
            ch_d    = '0;
         end
         SCAN: if (ch_q == CHW'(CHANNELS - 1)) begin
            state_d = IDLE;
         end else begin
            ch_d = ch_q + CHW'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_q == SCAN);
   end

   // One channel per scan cycle: a matching sample clears its count, enough differing samples flip the level.
   always_comb begin
      cnt_d      = cnt_q;
      out_d      = out_q;
      push       = 1'b0;
      push_level = ~out_q[ch_q];
      if (busy) begin
         if (sync2_q[ch_q] == out_q[ch_q]) begin
            cnt_d[ch_q] = '0;
         end else if (cnt_q[ch_q] == CNTW'(STABLE_CNT - 1)) begin
            out_d[ch_q] = ~out_q[ch_q];
            cnt_d[ch_q] = '0;
            push        = 1'b1;
         end else begin
            cnt_d[ch_q] = cnt_q[ch_q] + CNTW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_q <= '0;
         for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      end else begin
         out_q <= out_d;
         cnt_q <= cnt_d;
      end
   end

   assign pop = valid_q && evt_ready;

`ifdef DEBOUNCE_EVENT_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [EW-1:0] mem_q [FIFO_DEPTH];
   logic [EW-1:0] mem_d [FIFO_DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0]   count_q, count_d;
   logic          full;
   logic          wr_en;

   // A pop frees the slot the same cycle, so a full queue still accepts a push alongside a pop.
   always_comb begin
      mem_d   = mem_q;
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      full    = (count_q == (AW + 1)'(FIFO_DEPTH));
      wr_en   = push && (!full || pop);
      if (pop) rd_d = rd_q + AW'(1);
      if (wr_en) begin
         mem_d[wr_q] = {ch_q, push_level};
         wr_d        = wr_q + AW'(1);
      end else if (push) begin
         ovf_d = 1'b1;
      end
      if (wr_en && !pop) count_d = count_q + (AW + 1)'(1);
      else if (!wr_en && pop) count_d = count_q - (AW + 1)'(1);
      valid_d = (count_d != '0);
      head    = mem_q[rd_q];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         mem_q   <= mem_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end
`else
   logic [EW-1:0] hold_q, hold_d;
   logic          accept;

   always_comb begin
      hold_d  = hold_q;
      ovf_d   = ovf_q;
      valid_d = valid_q;
      accept  = push && (!valid_q || pop);
      if (accept) begin
         hold_d  = {ch_q, push_level};
         valid_d = 1'b1;
      end else begin
         if (push) ovf_d = 1'b1;
         if (pop) valid_d = 1'b0;
      end
      head = hold_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         hold_q  <= hold_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end
`endif

   assign signal_out   = out_q;
   assign evt_valid    = valid_q;
   assign evt_chan     = head[EW-1:1];
   assign evt_level    = head[0];
   assign evt_overflow = ovf_q;

endmodule
